// File: rtl/button_pkg.sv
// Shared definitions for the button gesture classifier: event codes,
// FSM state encoding and the system clock rate the timing parameters assume.
package button_pkg;

    localparam int unsigned CLK_HZ = 12000000;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_LONG   = 2'b10;
    localparam logic [1:0] EVT_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        HELD         = 2'b01,
        GAP          = 2'b10,
        WAIT_RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/event_fifo.sv
// Small show-ahead FIFO for classified button events. A push into a full
// queue is accepted only when a pop frees a slot in the same cycle.
module event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates everything that reads it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button gestures as SHORT, LONG or DOUBLE and queues
// them for the application FSM over a valid/ready handshake.
//
//   state        | meaning
//   IDLE         | released, waiting for a press edge
//   HELD         | pressed, timing toward LONG
//   GAP          | released after a short press, timing toward SHORT
//   WAIT_RELEASE | event already issued, ignore press until released
module button_event_ctrl
    import button_pkg::*;
#(
    parameter logic [31:0] LONG_TICKS = 32'd6000000,
    parameter logic [31:0] DOUBLE_GAP = 32'd3600000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press,
    output logic [1:0] evt_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       ovf,
    input  logic       ovf_clr
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        press_q;
    logic        ovf_q, ovf_d;
    logic        rise;
    logic        push_req;
    logic [1:0]  push_code;
    logic        fifo_empty, fifo_full;
    logic        drop;

    assign rise = press && !press_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push_req  = 1'b0;
        push_code = EVT_NONE;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HELD;
                    cnt_d   = 32'd1;
                end
            end
            HELD: begin
                if (press) begin
                    if (cnt_q == LONG_TICKS - 32'd1) begin
                        push_req  = 1'b1;
                        push_code = EVT_LONG;
                        state_d   = WAIT_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    state_d = GAP;
                    cnt_d   = 32'd1;
                end
            end
            GAP: begin
                if (press) begin
                    push_req  = 1'b1;
                    push_code = EVT_DOUBLE;
                    state_d   = WAIT_RELEASE;
                end else if (cnt_q == DOUBLE_GAP - 32'd1) begin
                    push_req  = 1'b1;
                    push_code = EVT_SHORT;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_RELEASE: begin
                if (!press) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full queue only drops when the consumer is not freeing a slot.
    assign drop = push_req && fifo_full && !evt_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // press_q resets high so a press held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press;
            ovf_q   <= ovf_d;
        end
    end

    event_fifo #(
        .WIDTH (2),
        .DEPTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_code),
        .pop   (evt_ready),
        .dout  (evt_code),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt_valid = !fifo_empty;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with LONG_TICKS=8, DOUBLE_GAP=5.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press = 1'b0;
    logic [1:0] evt_code;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    button_event_ctrl #(
        .LONG_TICKS (32'd8),
        .DOUBLE_GAP (32'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .press     (press),
        .evt_code  (evt_code),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic make_short();
        press = 1'b1;
        tick(2);
        press = 1'b0;
        tick(5);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00 || ovf !== 1'b0) begin
            $display("FAIL reset_in valid=%0b code=%b ovf=%0b exp 0/00/0", evt_valid, evt_code, ovf);
            failures++;
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00 || ovf !== 1'b0) begin
            $display("FAIL reset_out valid=%0b code=%b ovf=%0b exp 0/00/0", evt_valid, evt_code, ovf);
            failures++;
        end
    endtask

    task automatic test_short();
        press = 1'b1;
        tick(3);
        press = 1'b0;
        tick(4);
        checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL short_early valid=%0b exp 0 after 4 low samples", evt_valid);
            failures++;
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
            $display("FAIL short_evt valid=%0b code=%b exp 1/01", evt_valid, evt_code);
            failures++;
        end
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
            $display("FAIL short_hold valid=%0b code=%b exp 1/01", evt_valid, evt_code);
            failures++;
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00) begin
            $display("FAIL short_pop valid=%0b code=%b exp 0/00", evt_valid, evt_code);
            failures++;
        end
    endtask

    task automatic test_long();
        press = 1'b1;
        tick(7);
        checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL long_early valid=%0b exp 0 after 7 high samples", evt_valid);
            failures++;
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin
            $display("FAIL long_evt valid=%0b code=%b exp 1/10", evt_valid, evt_code);
            failures++;
        end
        tick(12);
        press = 1'b0;
        tick(10);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL long_single valid=%0b code=%b exp 0 after one pop", evt_valid, evt_code);
            failures++;
        end
    endtask

    task automatic test_double();
        press = 1'b1;
        tick(3);
        press = 1'b0;
        tick(2);
        press = 1'b1;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b11) begin
            $display("FAIL double_evt valid=%0b code=%b exp 1/11", evt_valid, evt_code);
            failures++;
        end
        tick(3);
        press = 1'b0;
        tick(10);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL double_nosec valid=%0b code=%b exp 0 after one pop", evt_valid, evt_code);
            failures++;
        end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) make_short();
        checks++;
        if (evt_valid !== 1'b1 || ovf !== 1'b0) begin
            $display("FAIL ovf_four valid=%0b ovf=%0b exp 1/0", evt_valid, ovf);
            failures++;
        end
        make_short();
        checks++;
        if (ovf !== 1'b1 || evt_code !== 2'b01) begin
            $display("FAIL ovf_set ovf=%0b code=%b exp 1/01", ovf, evt_code);
            failures++;
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL ovf_clr ovf=%0b exp 0", ovf);
            failures++;
        end
        // push coincident with pop at full
        press = 1'b1;
        tick(2);
        press = 1'b0;
        tick(4);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (ovf !== 1'b0 || evt_valid !== 1'b1) begin
            $display("FAIL ovf_pushpop ovf=%0b valid=%0b exp 0/1", ovf, evt_valid);
            failures++;
        end
        // drop and clear in the same cycle: set wins
        press = 1'b1;
        tick(2);
        press = 1'b0;
        tick(4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            $display("FAIL ovf_setwins ovf=%0b exp 1", ovf);
            failures++;
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        tick(3);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
            $display("FAIL ovf_count3 valid=%0b code=%b exp 1/01 after 3 pops", evt_valid, evt_code);
            failures++;
        end
        tick(1);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL ovf_count4 valid=%0b ovf=%0b exp 0/0 after 4 pops", evt_valid, ovf);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        make_short();
        press = 1'b1;
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00 || ovf !== 1'b0) begin
            $display("FAIL rstmid_async valid=%0b code=%b ovf=%0b exp 0/00/0", evt_valid, evt_code, ovf);
            failures++;
        end
        tick(1);
        rst = 1'b0;
        tick(20);
        checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL rstmid_held valid=%0b code=%b exp 0 while press held", evt_valid, evt_code);
            failures++;
        end
        press = 1'b0;
        tick(1);
        press = 1'b1;
        tick(8);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin
            $display("FAIL rstmid_relong valid=%0b code=%b exp 1/10", evt_valid, evt_code);
            failures++;
        end
        press = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        press = 1'b1;
        tick(8);
        press = 1'b0;
        tick(1);
        make_short();
        press = 1'b1;
        tick(2);
        press = 1'b0;
        tick(1);
        press = 1'b1;
        tick(1);
        press = 1'b0;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin
            $display("FAIL drain_c1 valid=%0b code=%b exp 1/10", evt_valid, evt_code);
            failures++;
        end
        evt_ready = 1'b1;
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
            $display("FAIL drain_c2 valid=%0b code=%b exp 1/01", evt_valid, evt_code);
            failures++;
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 2'b11) begin
            $display("FAIL drain_c3 valid=%0b code=%b exp 1/11", evt_valid, evt_code);
            failures++;
        end
        tick(1);
        checks++;
        if (evt_valid !== 1'b0 || evt_code !== 2'b00) begin
            $display("FAIL drain_c4 valid=%0b code=%b exp 0/00", evt_valid, evt_code);
            failures++;
        end
        tick(2);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL drain_empty_pop valid=%0b ovf=%0b exp 0/0", evt_valid, ovf);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
